// File: rtl/rv32_pkg.sv
// =====================================================================
// Module : rv32_pkg
// Shared types and constants for the multi-cycle RV32I memory sequencer
// Rev    : 1.0
// =====================================================================
`default_nettype none

package rv32_pkg;

    localparam int          XLEN   = 32;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_DATA   = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bus_wait_timer.sv
// =====================================================================
// Module : bus_wait_timer
// Counts bus wait cycles and pulses expired on the cycle the count hits TIMEOUT
// Rev    : 1.0
// =====================================================================
`default_nettype none

module bus_wait_timer #(
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic waiting,
    output logic expired
);

    localparam int c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Expiry fires on the wait cycle that would take the count to TIMEOUT.
    assign expired = (TIMEOUT != 0) && waiting && (r_cnt == c_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (waiting && !expired) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/core_mem_sequencer.sv
// =====================================================================
// Module : core_mem_sequencer
// Multi-cycle RV32I sequencer arbitrating one memory port between fetch and load/store
// Rev    : 1.0
// =====================================================================
`default_nettype none

module core_mem_sequencer
    import rv32_pkg::*;
#(
    parameter int             TIMEOUT   = 0,
    parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] instr_addr,
    input  logic [XLEN-1:0] data_mem_addr,
    input  logic [XLEN-1:0] write_data,
    input  logic [3:0]      wstrb,
    input  logic            mem_read,
    input  logic            mem_write,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] read_data,
    output logic            core_en,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_wstrb,
    input  logic            bus_ready,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            bus_err
);

    state_t r_state;
    state_t w_next;
    logic   w_waiting;
    logic   w_expired;

    // Derived from the state register so bus_ready never feeds back into bus_req.
    assign w_waiting = ((r_state == ST_FETCH) || (r_state == ST_DATA)) && !bus_ready;

    bus_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .waiting (w_waiting),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = instr_addr;
        bus_wdata = '0;
        bus_wstrb = 4'hF;
        core_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next = ST_FETCH;
            end
            ST_FETCH: begin
                bus_req = 1'b1;
                if (bus_ready || w_expired) begin
                    w_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (mem_read || mem_write) begin
                    w_next = ST_DATA;
                end else begin
                    core_en = 1'b1;
                    w_next  = ST_FETCH;
                end
            end
            ST_DATA: begin
                bus_req  = 1'b1;
                bus_addr = data_mem_addr;
                // A simultaneous read+write decode is resolved as a store.
                if (mem_write) begin
                    bus_we    = 1'b1;
                    bus_wdata = write_data;
                    bus_wstrb = wstrb;
                end
                if (bus_ready || w_expired) begin
                    w_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                core_en = 1'b1;
                w_next  = ST_FETCH;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr     <= NOP_INSTR;
            read_data <= '0;
            bus_err   <= 1'b0;
        end else begin
            if (r_state == ST_FETCH) begin
                if (bus_ready) begin
                    instr <= bus_rdata;
                end else if (w_expired) begin
                    instr   <= NOP_INSTR;
                    bus_err <= 1'b1;
                end
            end
            if (r_state == ST_DATA) begin
                if (bus_ready) begin
                    if (!mem_write) begin
                        read_data <= bus_rdata;
                    end
                end else if (w_expired) begin
                    read_data <= '0;
                    bus_err   <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_core_mem_sequencer.sv
// =====================================================================
// Module : tb_core_mem_sequencer
// Directed cycle-table bench for core_mem_sequencer with TIMEOUT=4
// Rev    : 1.0
// =====================================================================
`default_nettype none

module tb_core_mem_sequencer;

    localparam logic [31:0] c_nop  = 32'h0000_0013;
    localparam logic [31:0] c_addi = 32'h0050_0093;
    localparam logic [31:0] c_lw   = 32'h1000_2083;
    localparam logic [31:0] c_sw   = 32'h0020_A023;
    localparam logic [31:0] c_db   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instr_addr, data_mem_addr, write_data, bus_rdata;
    logic [3:0]  wstrb;
    logic        mem_read, mem_write, bus_ready;
    logic [31:0] instr, read_data, bus_addr, bus_wdata;
    logic        core_en, bus_req, bus_we, bus_err;
    logic [3:0]  bus_wstrb;

    core_mem_sequencer #(
        .TIMEOUT   (4),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .instr_addr    (instr_addr),
        .data_mem_addr (data_mem_addr),
        .write_data    (write_data),
        .wstrb         (wstrb),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .instr         (instr),
        .read_data     (read_data),
        .core_en       (core_en),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_wstrb     (bus_wstrb),
        .bus_ready     (bus_ready),
        .bus_rdata     (bus_rdata),
        .bus_err       (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rdy;
        logic [31:0] rdata;
        logic        mr;
        logic        mw;
        logic [31:0] pc;
        logic [31:0] da;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_ws;
        logic [31:0] e_wd;
        logic        e_en;
        logic [31:0] e_instr;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    vec_t v;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic [31:0] rdata, input logic mr, input logic mw,
                       input logic [31:0] pc, input logic [31:0] da, input logic [31:0] wd,
                       input logic [3:0] ws, input logic e_req, input logic e_we,
                       input logic [31:0] e_addr, input logic [3:0] e_ws, input logic [31:0] e_wd,
                       input logic e_en, input logic [31:0] e_instr, input logic [31:0] e_rdata,
                       input logic e_err);
        vec_t t;
        t = '{rdy, rdata, mr, mw, pc, da, wd, ws, e_req, e_we, e_addr, e_ws, e_wd,
              e_en, e_instr, e_rdata, e_err};
        vecs.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          waits;
        int          fetches;
        int          ens;
        int          cyc;
        logic        prev_en;
        logic [31:0] exp_instr;

        reset_n = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
        instr_addr = '0; data_mem_addr = '0; write_data = '0; wstrb = 4'h0;
        mem_read = 1'b0; mem_write = 1'b0;

        //   rdy rdata        mr mw pc  da      wd            ws    | req we addr    ws    wd            en instr   rdata err
        add(0, 0,            0, 0, 0,  0,      0,            4'h0,   0, 0, 0,      4'hF, 0,            0, c_nop,  0,    0); // IDLE
        add(1, c_addi,       0, 0, 0,  0,      0,            4'h0,   1, 0, 0,      4'hF, 0,            0, c_nop,  0,    0); // FETCH
        add(0, 0,            0, 0, 0,  0,      0,            4'h0,   0, 0, 0,      4'hF, 0,            1, c_addi, 0,    0); // DECODE retire
        add(1, c_lw,         0, 0, 4,  0,      0,            4'h0,   1, 0, 4,      4'hF, 0,            0, c_addi, 0,    0);
        add(0, 0,            1, 0, 4,  32'h100, 0,           4'h0,   0, 0, 0,      4'hF, 0,            0, c_lw,   0,    0);
        for (int k = 0; k < 3; k++)
            add(0, 0,        1, 0, 4,  32'h100, 0,           4'h0,   1, 0, 32'h100, 4'hF, 0,           0, c_lw,   0,    0); // data waits
        add(1, c_db,         1, 0, 4,  32'h100, 0,           4'h0,   1, 0, 32'h100, 4'hF, 0,           0, c_lw,   0,    0);
        add(0, 0,            1, 0, 4,  32'h100, 0,           4'h0,   0, 0, 0,      4'hF, 0,            1, c_lw,   c_db, 0); // COMMIT
        add(1, c_sw,         0, 0, 8,  0,      0,            4'h0,   1, 0, 8,      4'hF, 0,            0, c_lw,   c_db, 0);
        add(0, 0,            0, 1, 8,  32'h200, 32'h12345678, 4'h3,  0, 0, 0,      4'hF, 0,            0, c_sw,   c_db, 0);
        add(1, 32'h5555_5555, 0, 1, 8, 32'h200, 32'h12345678, 4'h3,  1, 1, 32'h200, 4'h3, 32'h12345678, 0, c_sw,  c_db, 0);
        add(0, 0,            0, 1, 8,  32'h200, 32'h12345678, 4'h3,  0, 0, 0,      4'hF, 0,            1, c_sw,   c_db, 0);
        for (int k = 0; k < 4; k++)
            add(0, 0,        0, 0, 12, 0,      0,            4'h0,   1, 0, 12,     4'hF, 0,            0, c_sw,   c_db, 0); // fetch stall
        add(0, 0,            0, 0, 12, 0,      0,            4'h0,   0, 0, 0,      4'hF, 0,            1, c_nop,  c_db, 1); // timed out
        add(1, c_addi,       0, 0, 16, 0,      0,            4'h0,   1, 0, 16,     4'hF, 0,            0, c_nop,  c_db, 1);
        add(0, 0,            0, 0, 16, 0,      0,            4'h0,   0, 0, 0,      4'hF, 0,            1, c_addi, c_db, 1);
        add(1, c_lw,         0, 0, 20, 0,      0,            4'h0,   1, 0, 20,     4'hF, 0,            0, c_addi, c_db, 1);
        add(0, 0,            1, 1, 20, 32'h300, 32'hA5A5A5A5, 4'hC,  0, 0, 0,      4'hF, 0,            0, c_lw,   c_db, 1);
        add(1, 32'hCAFE_F00D, 1, 1, 20, 32'h300, 32'hA5A5A5A5, 4'hC, 1, 1, 32'h300, 4'hC, 32'hA5A5A5A5, 0, c_lw,  c_db, 1); // rd+wr = write
        add(0, 0,            1, 1, 20, 32'h300, 32'hA5A5A5A5, 4'hC,  0, 0, 0,      4'hF, 0,            1, c_lw,   c_db, 1);

        repeat (3) step();
        chk("reset bus_req",   {31'b0, bus_req}, 32'd0);
        chk("reset core_en",   {31'b0, core_en}, 32'd0);
        chk("reset instr",     instr, c_nop);
        chk("reset read_data", read_data, 32'd0);
        chk("reset bus_err",   {31'b0, bus_err}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            bus_ready = v.rdy; bus_rdata = v.rdata; mem_read = v.mr; mem_write = v.mw;
            instr_addr = v.pc; data_mem_addr = v.da; write_data = v.wd; wstrb = v.ws;
            #1;
            chk($sformatf("v%0d bus_req", i),   {31'b0, bus_req}, {31'b0, v.e_req});
            chk($sformatf("v%0d core_en", i),   {31'b0, core_en}, {31'b0, v.e_en});
            chk($sformatf("v%0d instr", i),     instr, v.e_instr);
            chk($sformatf("v%0d read_data", i), read_data, v.e_rdata);
            chk($sformatf("v%0d bus_err", i),   {31'b0, bus_err}, {31'b0, v.e_err});
            if (v.e_req) begin
                chk($sformatf("v%0d bus_addr", i),  bus_addr, v.e_addr);
                chk($sformatf("v%0d bus_we", i),    {31'b0, bus_we}, {31'b0, v.e_we});
                chk($sformatf("v%0d bus_wstrb", i), {28'b0, bus_wstrb}, {28'b0, v.e_ws});
                if (v.e_we)
                    chk($sformatf("v%0d bus_wdata", i), bus_wdata, v.e_wd);
            end
            step();
        end

        // Reset asserted in the middle of a load's data wait.
        bus_ready = 1'b1; bus_rdata = c_lw; mem_read = 1'b0; mem_write = 1'b0; instr_addr = 32'd24;
        #1 chk("rst_seq fetch req", {31'b0, bus_req}, 32'd1);
        step();
        mem_read = 1'b1; data_mem_addr = 32'h100; bus_ready = 1'b0;
        step();
        #1 chk("rst_seq data req", {31'b0, bus_req}, 32'd1);
        step();
        #1 reset_n = 1'b0;
        #1;
        chk("rst_seq async bus_req",   {31'b0, bus_req}, 32'd0);
        chk("rst_seq async core_en",   {31'b0, core_en}, 32'd0);
        chk("rst_seq async instr",     instr, c_nop);
        chk("rst_seq async bus_err",   {31'b0, bus_err}, 32'd0);
        chk("rst_seq async read_data", read_data, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_seq held core_en", {31'b0, core_en}, 32'd0);
        end
        mem_read = 1'b0; instr_addr = 32'd0;
        reset_n = 1'b1;
        #1 chk("rst_seq idle bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst_seq idle core_en", {31'b0, core_en}, 32'd0);
        step();

        // Back-to-back ALU instructions with 0-2 random wait states per fetch.
        waits = int'($urandom_range(0, 2));
        fetches = 0; ens = 0; cyc = 0; prev_en = 1'b0; exp_instr = c_nop;
        while (fetches < 30 && cyc < 400) begin
            if (bus_req) begin
                if (waits == 0) begin
                    bus_ready = 1'b1;
                    bus_rdata = 32'h0000_0013 | (32'(fetches + 1) << 20);
                end else begin
                    bus_ready = 1'b0;
                    waits--;
                end
            end else begin
                bus_ready = 1'b0;
            end
            #1;
            chk("rnd core_en back-to-back", {31'b0, core_en & prev_en}, 32'd0);
            chk("rnd instr", instr, exp_instr);
            if (core_en) ens++;
            if (bus_req && bus_ready) begin
                fetches++;
                exp_instr = bus_rdata;
                waits = int'($urandom_range(0, 2));
            end
            prev_en = core_en;
            step();
            if (prev_en) instr_addr = instr_addr + 32'd4;
            cyc++;
        end
        bus_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rnd tail back-to-back", {31'b0, core_en & prev_en}, 32'd0);
            if (core_en) ens++;
            prev_en = core_en;
            step();
        end
        chk("rnd fetch count", 32'(fetches), 32'd30);
        chk("rnd retire count", 32'(ens), 32'(fetches));
        chk("rnd final instr", instr, exp_instr);
        chk("rnd bus_err", {31'b0, bus_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
